// File: rtl/wifire_pkg.sv
// Shared constants and types for the 802.15.4 receive capture queue.
package wifire_pkg;

  localparam logic [8:0] WF_W_LEN     = 9'd0;
  localparam logic [8:0] WF_W_FCTRL   = 9'd1;
  localparam logic [8:0] WF_W_SEQNO   = 9'd2;
  localparam logic [8:0] WF_W_DST_PAN = 9'd3;
  localparam logic [8:0] WF_W_DST_HI  = 9'd4;
  localparam logic [8:0] WF_W_DST_LO  = 9'd5;
  localparam logic [8:0] WF_W_SRC_PAN = 9'd6;
  localparam logic [8:0] WF_W_SRC_HI  = 9'd7;
  localparam logic [8:0] WF_W_SRC_LO  = 9'd8;
  localparam logic [8:0] WF_W_SFD_HI  = 9'd9;
  localparam logic [8:0] WF_W_SFD_LO  = 9'd10;
  localparam logic [8:0] WF_W_NBYTES  = 9'd11;
  localparam logic [8:0] WF_W_TIME_HI = 9'd12;
  localparam logic [8:0] WF_W_TIME_LO = 9'd13;
  localparam logic [8:0] WF_W_STATUS  = 9'd14;

  localparam int WF_S_CTRL    = 0;
  localparam int WF_S_POP     = 1;
  localparam int WF_S_OVF_CLR = 2;

  typedef logic [1:0] wf_state_t;
  localparam wf_state_t ST_IDLE     = 2'd0;
  localparam wf_state_t ST_WAIT_HDR = 2'd1;
  localparam wf_state_t ST_CAPTURE  = 2'd2;
  localparam wf_state_t ST_DROP     = 2'd3;

  typedef struct packed {
    logic [6:0]  len;
    logic [15:0] frame_ctrl;
    logic [7:0]  seqno;
    logic [15:0] dst_pan;
    logic [63:0] dst_addr;
    logic [15:0] src_pan;
    logic [63:0] src_addr;
    logic [63:0] sfd_tics;
    logic [15:0] nbytes;
    logic        trunc;
  } wf_hdr_t;

endpackage

// File: rtl/wifire_msdu_ram.sv
// MSDU byte store: four byte-wide banks, byte write port, registered 32-bit read port.
module wifire_msdu_ram #(
  parameter int NSLOTS     = 4,
  parameter int MSDU_DEPTH = 128,
  parameter int TW         = $clog2(NSLOTS * MSDU_DEPTH)
) (
  input  logic          dsp_clk,
  input  logic          we_i,
  input  logic [TW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [TW-3:0] raddr_i,
  output logic [31:0]   rdata_o
);

  localparam int ROWS = NSLOTS * MSDU_DEPTH / 4;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem_q [ROWS];
    logic [7:0] rd_q;

    always_ff @(posedge dsp_clk) begin
      if (we_i && waddr_i[1:0] == 2'(b)) mem_q[waddr_i[TW-1:2]] <= wdata_i;
      rd_q <= mem_q[raddr_i];
    end

    assign rdata_o[8*b +: 8] = rd_q;
  end

endmodule

// File: rtl/wifire_rx_queue.sv
// Multi-slot receive capture queue with PAN filter, overflow accounting and Wishbone head read-out.
// state    | meaning
// IDLE     | waiting for SFD
// WAIT_HDR | SFD seen, waiting for decoded header
// CAPTURE  | storing MSDU bytes into slot wr_ptr
// DROP     | frame rejected, waiting for MSDU end
module wifire_rx_queue
  import wifire_pkg::*;
#(
  parameter int BASE       = 0,
  parameter int NSLOTS     = 4,
  parameter int MSDU_DEPTH = 128
) (
  input  logic        dsp_clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        sfd_i,
  input  logic        hdr_valid_i,
  input  logic        msdu_valid_i,
  input  logic [6:0]  len_i,
  input  logic [15:0] frame_ctrl_i,
  input  logic [7:0]  seqno_i,
  input  logic [15:0] dst_pan_i,
  input  logic [15:0] src_pan_i,
  input  logic [63:0] dst_addr_i,
  input  logic [63:0] src_addr_i,
  input  logic [7:0]  msdu_i,
  input  logic [7:0]  msdu_pos_i,
  input  logic        msdu_stb_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic        irq_ovf_o
);

  localparam int PW = $clog2(NSLOTS);
  localparam int CW = $clog2(NSLOTS) + 1;
  localparam int AW = $clog2(MSDU_DEPTH);
  localparam int TW = PW + AW;
  localparam logic [31:0] DEPTH32 = 32'(MSDU_DEPTH);
  localparam logic [7:0] A_CTRL = 8'(BASE + WF_S_CTRL);
  localparam logic [7:0] A_POP  = 8'(BASE + WF_S_POP);
  localparam logic [7:0] A_OVF  = 8'(BASE + WF_S_OVF_CLR);

  wf_state_t   state_q, state_d;
  logic        enable_q, enable_d, filter_en_q, filter_en_d;
  logic [15:0] my_pan_q, my_pan_d, ovf_cnt_q, ovf_cnt_d, nbytes_q, nbytes_d;
  logic [63:0] time_q, time_d, sfd_tics_q, sfd_tics_d;
  logic        hdr_valid_q, msdu_valid_q, irq_ovf_q, irq_ovf_d, trunc_q, trunc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wf_hdr_t     slots_q [NSLOTS];
  wf_hdr_t     slots_d [NSLOTS];
  logic        ack_q, ack_d, msdu_sel_q, msdu_sel_d;
  logic [31:0] hdr_dat_q, hdr_dat_d, hdr_word, ram_rdata;

  logic        hdr_rise, msdu_fall, full, empty, pop, commit, ovf_inc, ram_we;
  logic [15:0] pos1;
  logic [8:0]  wb_word;
  logic [TW-1:0] waddr, byte_ra;
  wf_hdr_t     head;
  logic        unused_bits;

  assign hdr_rise  = hdr_valid_i & ~hdr_valid_q;
  assign msdu_fall = msdu_valid_q & ~msdu_valid_i;
  assign full      = count_q == CW'(NSLOTS);
  assign empty     = count_q == '0;
  assign pop       = set_stb && set_addr == A_POP && !empty;
  assign pos1      = 16'(msdu_pos_i) + 16'd1;
  assign waddr     = {wr_ptr_q, AW'(msdu_pos_i)};
  assign wb_word   = wb_adr_i[10:2];
  assign byte_ra   = {rd_ptr_q, AW'({wb_word, 2'b00})};
  assign unused_bits = ^{set_data[15:2], wb_adr_i[15:12], wb_adr_i[1:0], byte_ra[1:0]};

  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    filter_en_d = filter_en_q;
    my_pan_d    = my_pan_q;
    time_d      = time_q + 64'd1;
    sfd_tics_d  = sfd_i ? time_q : sfd_tics_q;
    irq_ovf_d   = 1'b0;
    trunc_d     = trunc_q;
    nbytes_d    = nbytes_q;
    slots_d     = slots_q;
    commit      = 1'b0;
    ovf_inc     = 1'b0;
    ram_we      = 1'b0;

    if (set_stb && set_addr == A_CTRL) begin
      enable_d    = set_data[0];
      filter_en_d = set_data[1];
      my_pan_d    = set_data[31:16];
    end

    // A new SFD always restarts the frame, discarding anything in flight.
    if (!enable_q) state_d = ST_IDLE;
    else if (sfd_i) state_d = ST_WAIT_HDR;
    else begin
      case (state_q)
        ST_WAIT_HDR: if (hdr_rise) begin
          if (full || (filter_en_q && dst_pan_i != my_pan_q && dst_pan_i != 16'hFFFF)) begin
            state_d   = ST_DROP;
            irq_ovf_d = 1'b1;
            ovf_inc   = full;
          end else begin
            state_d  = ST_CAPTURE;
            trunc_d  = 1'b0;
            nbytes_d = '0;
            slots_d[wr_ptr_q] = '{len: len_i, frame_ctrl: frame_ctrl_i, seqno: seqno_i,
                                  dst_pan: dst_pan_i, dst_addr: dst_addr_i, src_pan: src_pan_i,
                                  src_addr: src_addr_i, sfd_tics: sfd_tics_q, nbytes: 16'd0,
                                  trunc: 1'b0};
          end
        end
        ST_CAPTURE: begin
          if (msdu_stb_i) begin
            if ({24'b0, msdu_pos_i} < DEPTH32) begin
              ram_we = 1'b1;
              if (pos1 > nbytes_q) nbytes_d = pos1;
            end else trunc_d = 1'b1;
          end
          if (msdu_fall) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
            slots_d[wr_ptr_q].nbytes = nbytes_d;
            slots_d[wr_ptr_q].trunc  = trunc_d;
          end
        end
        ST_DROP: if (msdu_fall) state_d = ST_IDLE;
        default: ;
      endcase
    end

    wr_ptr_d = wr_ptr_q + PW'(commit);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(commit) - CW'(pop);
    if (set_stb && set_addr == A_OVF) ovf_cnt_d = '0;
    else if (ovf_inc && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    else ovf_cnt_d = ovf_cnt_q;
  end

  always_comb begin
    head     = slots_q[rd_ptr_q];
    hdr_word = '0;
    case (wb_word)
      WF_W_LEN:     hdr_word = 32'(head.len);
      WF_W_FCTRL:   hdr_word = 32'(head.frame_ctrl);
      WF_W_SEQNO:   hdr_word = 32'(head.seqno);
      WF_W_DST_PAN: hdr_word = 32'(head.dst_pan);
      WF_W_DST_HI:  hdr_word = head.dst_addr[63:32];
      WF_W_DST_LO:  hdr_word = head.dst_addr[31:0];
      WF_W_SRC_PAN: hdr_word = 32'(head.src_pan);
      WF_W_SRC_HI:  hdr_word = head.src_addr[63:32];
      WF_W_SRC_LO:  hdr_word = head.src_addr[31:0];
      WF_W_SFD_HI:  hdr_word = head.sfd_tics[63:32];
      WF_W_SFD_LO:  hdr_word = head.sfd_tics[31:0];
      WF_W_NBYTES:  hdr_word = {15'b0, head.trunc, head.nbytes};
      WF_W_TIME_HI: hdr_word = time_q[63:32];
      WF_W_TIME_LO: hdr_word = time_q[31:0];
      WF_W_STATUS:  hdr_word = {ovf_cnt_q, 3'b0, 5'(count_q), 6'b0, full, empty};
      default:      ;
    endcase
    if (empty && wb_word <= WF_W_NBYTES) hdr_word = '0;

    ack_d      = wb_stb_i & ~ack_q;
    hdr_dat_d  = (wb_stb_i && !wb_we_i) ? hdr_word : '0;
    msdu_sel_d = wb_stb_i & ~wb_we_i & wb_adr_i[11];
  end

  always_ff @(posedge dsp_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      enable_q     <= 1'b0;
      filter_en_q  <= 1'b0;
      my_pan_q     <= '0;
      time_q       <= '0;
      sfd_tics_q   <= '0;
      hdr_valid_q  <= 1'b0;
      msdu_valid_q <= 1'b0;
      irq_ovf_q    <= 1'b0;
      trunc_q      <= 1'b0;
      nbytes_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_cnt_q    <= '0;
      slots_q      <= '{default: '0};
      ack_q        <= 1'b0;
      msdu_sel_q   <= 1'b0;
      hdr_dat_q    <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      filter_en_q  <= filter_en_d;
      my_pan_q     <= my_pan_d;
      time_q       <= time_d;
      sfd_tics_q   <= sfd_tics_d;
      hdr_valid_q  <= hdr_valid_i;
      msdu_valid_q <= msdu_valid_i;
      irq_ovf_q    <= irq_ovf_d;
      trunc_q      <= trunc_d;
      nbytes_q     <= nbytes_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_cnt_q    <= ovf_cnt_d;
      slots_q      <= slots_d;
      ack_q        <= ack_d;
      msdu_sel_q   <= msdu_sel_d;
      hdr_dat_q    <= hdr_dat_d;
    end
  end

  wifire_msdu_ram #(.NSLOTS(NSLOTS), .MSDU_DEPTH(MSDU_DEPTH), .TW(TW)) u_ram (
    .dsp_clk (dsp_clk),
    .we_i    (ram_we),
    .waddr_i (waddr),
    .wdata_i (msdu_i),
    .raddr_i (byte_ra[TW-1:2]),
    .rdata_o (ram_rdata)
  );

  // RAM data arrives in the ack cycle, so the MSDU path bypasses the header register.
  assign wb_dat_o  = ack_q ? (msdu_sel_q ? ram_rdata : hdr_dat_q) : '0;
  assign wb_ack_o  = ack_q;
  assign irq_o     = !empty;
  assign irq_ovf_o = irq_ovf_q;

endmodule

// File: tb/tb_wifire_rx_queue.sv
// Bench for wifire_rx_queue: main instance plus a 4-byte-deep instance for truncation.
module tb_wifire_rx_queue;

  logic        clk = 1'b0;
  logic        reset, set_stb, sfd, hdr_valid, msdu_valid, msdu_stb, wb_stb, wb_we;
  logic [7:0]  set_addr, seqno, msdu, msdu_pos;
  logic [31:0] set_data;
  logic [6:0]  len;
  logic [15:0] fctrl, dst_pan, src_pan, wb_adr;
  logic [63:0] dst_addr, src_addr;
  logic [31:0] wb_dat, wb_dat4;
  logic        wb_ack, wb_ack4, irq, irq4, irq_ovf, irq_ovf4;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;
  logic [63:0] tb_time = '0;
  logic [63:0] rd_time;

  typedef struct { logic [7:0] seqno; logic [31:0] nbytes; } sb_t;
  sb_t sb[$];

  typedef struct { string name; logic [15:0] adr; logic [31:0] exp; } rd_vec_t;
  rd_vec_t tbl[$];

  typedef struct { logic [15:0] pan; bit accept; } flt_vec_t;
  flt_vec_t ftbl[$];

  always #5 clk = ~clk;

  always @(posedge clk) tb_time <= reset ? 64'd0 : tb_time + 64'd1;
  always @(negedge clk) if (irq_ovf === 1'b1) ovf_pulses++;

  wifire_rx_queue u_dut (
    .dsp_clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sfd_i(sfd), .hdr_valid_i(hdr_valid), .msdu_valid_i(msdu_valid), .len_i(len),
    .frame_ctrl_i(fctrl), .seqno_i(seqno), .dst_pan_i(dst_pan), .src_pan_i(src_pan),
    .dst_addr_i(dst_addr), .src_addr_i(src_addr), .msdu_i(msdu), .msdu_pos_i(msdu_pos),
    .msdu_stb_i(msdu_stb), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
    .wb_dat_o(wb_dat), .wb_ack_o(wb_ack), .irq_o(irq), .irq_ovf_o(irq_ovf)
  );

  wifire_rx_queue #(.NSLOTS(4), .MSDU_DEPTH(4)) u_dut4 (
    .dsp_clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sfd_i(sfd), .hdr_valid_i(hdr_valid), .msdu_valid_i(msdu_valid), .len_i(len),
    .frame_ctrl_i(fctrl), .seqno_i(seqno), .dst_pan_i(dst_pan), .src_pan_i(src_pan),
    .dst_addr_i(dst_addr), .src_addr_i(src_addr), .msdu_i(msdu), .msdu_pos_i(msdu_pos),
    .msdu_stb_i(msdu_stb), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
    .wb_dat_o(wb_dat4), .wb_ack_o(wb_ack4), .irq_o(irq4), .irq_ovf_o(irq_ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] adr, output logic [31:0] d, output logic [31:0] d4);
    int n = 0;
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1; rd_time = tb_time;
    tick();
    while (wb_ack !== 1'b1 && n < 4) begin tick(); n++; end
    wb_stb = 1'b0;
    if (wb_ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout: got no ack for address %h", adr);
    end
    d = wb_dat; d4 = wb_dat4;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] seq, input logic [15:0] pan, input int nb,
                            input bit pop_end, output logic [63:0] sfd_t);
    sfd = 1'b1; hdr_valid = 1'b0; msdu_valid = 1'b0; sfd_t = tb_time;
    tick();
    sfd = 1'b0; seqno = seq; dst_pan = pan;
    tick();
    hdr_valid = 1'b1; tick();
    msdu_valid = 1'b1; tick();
    for (int i = 0; i < nb; i++) begin
      msdu_stb = 1'b1; msdu_pos = 8'(i); msdu = 8'(i + 1);
      tick();
    end
    msdu_stb = 1'b0; tick();
    msdu_valid = 1'b0;
    if (pop_end) begin set_stb = 1'b1; set_addr = 8'd1; end
    tick();
    set_stb = 1'b0; hdr_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic partial_frame(input logic [7:0] seq);
    sfd = 1'b1; hdr_valid = 1'b0; msdu_valid = 1'b0;
    tick();
    sfd = 1'b0; seqno = seq; tick();
    hdr_valid = 1'b1; tick();
    msdu_valid = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      msdu_stb = 1'b1; msdu_pos = 8'(i); msdu = 8'hE0 + 8'(i);
      tick();
    end
    msdu_stb = 1'b0; tick();
  endtask

  task automatic pop_and_check(input string tag);
    sb_t e;
    logic [31:0] d, d4;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb_empty: got pop request expected queued frame", tag);
      return;
    end
    e = sb.pop_front();
    wb_read(16'(2 * 4), d, d4);
    check({tag, "_seqno"}, 64'(d), 64'(e.seqno));
    wb_read(16'(11 * 4), d, d4);
    check({tag, "_nbytes"}, 64'(d), 64'(e.nbytes));
    set_write(8'd1, 32'd0);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d, d4;
    wb_read(16'(14 * 4), d, d4);
    check(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d4;
    logic [63:0] st;
    int p0, cnt;

    reset = 1'b1; set_stb = 0; set_addr = 0; set_data = 0; sfd = 0; hdr_valid = 0;
    msdu_valid = 0; msdu_stb = 0; msdu = 0; msdu_pos = 0; wb_stb = 0; wb_we = 0; wb_adr = 0;
    len = 7'd21; fctrl = 16'hA1B2; seqno = 0; dst_pan = 0; src_pan = 16'hCAFE;
    dst_addr = 64'h1122_3344_5566_7788; src_addr = 64'h99AA_BBCC_DDEE_FF00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_irq", 64'(irq), 64'd0);
    check("rst_irq_ovf", 64'(irq_ovf), 64'd0);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_dat", 64'(wb_dat), 64'd0);
    check("rst_irq4", 64'(irq4), 64'd0);
    check_status("rst_status", 32'h0000_0001);

    wb_adr = 16'h0038; wb_we = 1'b0; wb_stb = 1'b1;
    tick();
    check("ack_rise", 64'(wb_ack), 64'd1);
    tick();
    check("ack_single_pulse", 64'(wb_ack), 64'd0);
    wb_stb = 1'b0;
    tick();

    // single frame
    set_write(8'd0, 32'h0000_0001);
    send_frame(8'h5A, 16'hABCD, 10, 1'b0, st);
    sb.push_back('{8'h5A, 32'd10});
    check("single_irq", 64'(irq), 64'd1);
    tbl.push_back('{"w_len",     16'h0000, 32'd21});
    tbl.push_back('{"w_fctrl",   16'h0004, 32'h0000_A1B2});
    tbl.push_back('{"w_seqno",   16'h0008, 32'h0000_005A});
    tbl.push_back('{"w_dst_pan", 16'h000C, 32'h0000_ABCD});
    tbl.push_back('{"w_dst_hi",  16'h0010, 32'h1122_3344});
    tbl.push_back('{"w_dst_lo",  16'h0014, 32'h5566_7788});
    tbl.push_back('{"w_src_pan", 16'h0018, 32'h0000_CAFE});
    tbl.push_back('{"w_src_hi",  16'h001C, 32'h99AA_BBCC});
    tbl.push_back('{"w_src_lo",  16'h0020, 32'hDDEE_FF00});
    tbl.push_back('{"w_sfd_hi",  16'h0024, st[63:32]});
    tbl.push_back('{"w_sfd_lo",  16'h0028, st[31:0]});
    tbl.push_back('{"w_nbytes",  16'h002C, 32'd10});
    tbl.push_back('{"w_status",  16'h0038, 32'h0000_0100});
    tbl.push_back('{"w_unused",  16'h003C, 32'h0000_0000});
    tbl.push_back('{"msdu_w0",   16'h0800, 32'h0403_0201});
    tbl.push_back('{"msdu_w1",   16'h0804, 32'h0807_0605});
    foreach (tbl[i]) begin
      wb_read(tbl[i].adr, d, d4);
      check(tbl[i].name, 64'(d), 64'(tbl[i].exp));
    end
    wb_read(16'h0034, d, d4);
    check("time_lo", 64'(d), 64'(rd_time[31:0]));
    wb_read(16'h002C, d, d4);
    check("trunc_nbytes_d4", 64'(d4), 64'h0001_0004);
    wb_read(16'h0800, d, d4);
    check("trunc_msdu_d4", 64'(d4), 64'h0403_0201);
    pop_and_check("single");
    check("pop_irq", 64'(irq), 64'd0);
    check_status("pop_status", 32'h0000_0001);

    // fill and overflow
    p0 = ovf_pulses;
    for (int i = 0; i < 6; i++) begin
      send_frame(8'h10 + 8'(i), 16'h0001, 4, 1'b0, st);
      if (i < 4) sb.push_back('{8'h10 + 8'(i), 32'd4});
    end
    check("fill_ovf_pulses", 64'(ovf_pulses - p0), 64'd2);
    check_status("fill_status", 32'h0002_0402);
    pop_and_check("fill_first");
    send_frame(8'h16, 16'h0001, 4, 1'b0, st);
    sb.push_back('{8'h16, 32'd4});
    check_status("refill_status", 32'h0002_0402);
    repeat (4) pop_and_check("fill_drain");
    set_write(8'd2, 32'd0);
    check_status("ovf_clear_status", 32'h0000_0001);

    // destination PAN filter
    set_write(8'd0, 32'h1234_0003);
    ftbl.push_back('{16'h1234, 1'b1});
    ftbl.push_back('{16'hFFFF, 1'b1});
    ftbl.push_back('{16'h4321, 1'b0});
    ftbl.push_back('{16'h1235, 1'b0});
    cnt = 0;
    foreach (ftbl[i]) begin
      p0 = ovf_pulses;
      send_frame(8'h20 + 8'(i), ftbl[i].pan, 3, 1'b0, st);
      if (ftbl[i].accept) begin
        sb.push_back('{8'h20 + 8'(i), 32'd3});
        cnt++;
      end
      check("filter_pulse", 64'(ovf_pulses - p0), ftbl[i].accept ? 64'd0 : 64'd1);
      check_status("filter_status", (32'(cnt) << 8) | 32'(cnt == 0));
    end
    repeat (2) pop_and_check("filter");
    set_write(8'd0, 32'h0000_0001);

    // abort mid-capture
    partial_frame(8'h30);
    send_frame(8'h31, 16'h0001, 5, 1'b0, st);
    sb.push_back('{8'h31, 32'd5});
    check_status("abort_status", 32'h0000_0100);
    pop_and_check("abort");

    // simultaneous commit and pop
    send_frame(8'h40, 16'h0001, 2, 1'b0, st);
    sb.push_back('{8'h40, 32'd2});
    send_frame(8'h41, 16'h0001, 3, 1'b0, st);
    sb.push_back('{8'h41, 32'd3});
    send_frame(8'h42, 16'h0001, 4, 1'b1, st);
    sb.push_back('{8'h42, 32'd4});
    void'(sb.pop_front());
    check_status("simul_status", 32'h0000_0200);
    repeat (2) pop_and_check("simul");

    // reset during capture
    partial_frame(8'h60);
    hdr_valid = 1'b0; msdu_valid = 1'b0; reset = 1'b1;
    tick(); tick();
    check("midrst_irq", 64'(irq), 64'd0);
    check("midrst_irq_ovf", 64'(irq_ovf), 64'd0);
    check("midrst_ack", 64'(wb_ack), 64'd0);
    check("midrst_dat", 64'(wb_dat), 64'd0);
    reset = 1'b0;
    sb.delete();
    tick();
    check_status("midrst_status", 32'h0000_0001);
    set_write(8'd0, 32'h0000_0001);
    send_frame(8'h61, 16'h0001, 7, 1'b0, st);
    sb.push_back('{8'h61, 32'd7});
    check("midrst_irq_after", 64'(irq), 64'd1);
    wb_read(16'h0028, d, d4);
    check("midrst_sfd_lo", 64'(d), 64'(st[31:0]));
    pop_and_check("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
